sm_step_multi: RTL and testbench

Multi-channel stepper-motor step generator running on the 50 MHz system clock. It supersedes the single-channel period-filling pulse block. Each channel has:
- a programmable period;
- a programmable step count;
- a direction output with a setup cycle;
- a fixed-width step pulse.

Each channel also has its own busy/done handshake, pause on enable, on-the-fly period retiming and a global abort. The block sits between the ADC/control sequencer, which supplies the load strobes, and the motor driver pins.

---
 rtl/sm_step_multi.sv | 158 +++++++++++++++
 tb/tb_sm_step_multi.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_step_multi.sv
// rtl/sm_step_multi.sv - multi-channel stepper step generator with pause, retime and abort
module sm_step_multi #(
    parameter int CH = 2,
    parameter int W  = 17,
    parameter int SW = 16,
    parameter int PW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH-1:0]   load,
    input  logic [CH*W-1:0] period,
    input  logic [CH*SW-1:0] steps,
    input  logic [CH-1:0]   dir_in,
    input  logic [CH-1:0]   enable,
    input  logic            abort,
    output logic [CH-1:0]   step,
    output logic [CH-1:0]   dir,
    output logic [CH-1:0]   busy,
    output logic [CH-1:0]   done
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN} state_t;

    // Shortest legal period leaves at least one low cycle after the pulse.
    localparam logic [W-1:0] PER_MIN = W'(PW + 1);
    localparam logic [W-1:0] PW_W    = W'(PW);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        state_t          state_q, state_d;
        logic [W-1:0]    per_r_q, per_r_d;
        logic [W-1:0]    per_pend_q, per_pend_d;
        logic [W-1:0]    phase_q, phase_d;
        logic [SW-1:0]   rem_q, rem_d;
        logic            pend_q, pend_d;
        logic            dir_q, dir_d;
        logic            done_ev_q, done_ev_d;
        logic            step_d, busy_d;
        logic            step_q, busy_q, done_q, dir_o_q;
        logic [W-1:0]    per_in, per_eff;
        logic [SW-1:0]   steps_in;
        logic            hold;

        assign per_in   = period[i*W +: W];
        assign steps_in = steps[i*SW +: SW];
        assign per_eff  = (per_in < PER_MIN) ? PER_MIN : per_in;
        // Pause only takes effect on the first cycle of a period.
        assign hold     = (phase_q == '0) && !enable[i];

        // Next-state logic: load/retime, period counting, pause and abort.
        always_comb begin
            state_d    = state_q;
            per_r_d    = per_r_q;
            per_pend_d = per_pend_q;
            phase_d    = phase_q;
            rem_d      = rem_q;
            pend_d     = pend_q;
            dir_d      = dir_q;
            done_ev_d  = 1'b0;
            step_d     = 1'b0;
            busy_d     = (state_q != S_IDLE);
            if (abort) begin
                state_d = S_IDLE;
                pend_d  = 1'b0;
                phase_d = '0;
                busy_d  = 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (load[i]) begin
                            if (steps_in != '0) begin
                                per_r_d = per_eff;
                                rem_d   = steps_in;
                                dir_d   = dir_in[i];
                                pend_d  = 1'b0;
                                state_d = S_SETUP;
                            end else begin
                                done_ev_d = 1'b1;
                            end
                        end
                    end
                    S_SETUP: begin
                        if (load[i]) begin
                            per_pend_d = per_eff;
                            pend_d     = 1'b1;
                        end
                        phase_d = '0;
                        state_d = S_RUN;
                    end
                    S_RUN: begin
                        if (load[i]) begin
                            per_pend_d = per_eff;
                            pend_d     = 1'b1;
                        end
                        step_d = (phase_q < PW_W) && !hold;
                        if (hold) begin
                            phase_d = '0;
                        end else if (phase_q == per_r_q - W'(1)) begin
                            rem_d   = rem_q - SW'(1);
                            phase_d = '0;
                            if (load[i]) begin
                                per_r_d = per_eff;
                                pend_d  = 1'b0;
                            end else if (pend_q) begin
                                per_r_d = per_pend_q;
                                pend_d  = 1'b0;
                            end
                            if (rem_q == SW'(1)) begin
                                state_d   = S_IDLE;
                                pend_d    = 1'b0;
                                done_ev_d = 1'b1;
                            end
                        end else begin
                            phase_d = phase_q + W'(1);
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end

        // State and registered outputs; outputs trail the FSM by one cycle.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q    <= S_IDLE;
                per_r_q    <= '0;
                per_pend_q <= '0;
                phase_q    <= '0;
                rem_q      <= '0;
                pend_q     <= 1'b0;
                dir_q      <= 1'b0;
                done_ev_q  <= 1'b0;
                step_q     <= 1'b0;
                busy_q     <= 1'b0;
                done_q     <= 1'b0;
                dir_o_q    <= 1'b0;
            end else begin
                state_q    <= state_d;
                per_r_q    <= per_r_d;
                per_pend_q <= per_pend_d;
                phase_q    <= phase_d;
                rem_q      <= rem_d;
                pend_q     <= pend_d;
                dir_q      <= dir_d;
                done_ev_q  <= done_ev_d;
                step_q     <= step_d;
                busy_q     <= busy_d;
                done_q     <= done_ev_q;
                dir_o_q    <= dir_q;
            end
        end

        assign step[i] = step_q;
        assign busy[i] = busy_q;
        assign done[i] = done_q;
        assign dir[i]  = dir_o_q;
    end

endmodule

// File: tb/tb_sm_step_multi.sv
// tb/tb_sm_step_multi.sv - scoreboard bench for sm_step_multi
module tb_sm_step_multi;

    localparam int CH = 2;
    localparam int W  = 17;
    localparam int SW = 16;
    localparam int PW = 4;
    localparam int NC = 1024;

    logic            clk = 1'b0;
    logic            rst;
    logic [CH-1:0]   load;
    logic [CH*W-1:0] period;
    logic [CH*SW-1:0] steps;
    logic [CH-1:0]   dir_in;
    logic [CH-1:0]   enable;
    logic            abort;
    logic [CH-1:0]   step;
    logic [CH-1:0]   dir;
    logic [CH-1:0]   busy;
    logic [CH-1:0]   done;

    sm_step_multi #(.CH(CH), .W(W), .SW(SW), .PW(PW)) dut (
        .clk(clk), .rst(rst), .load(load), .period(period), .steps(steps),
        .dir_in(dir_in), .enable(enable), .abort(abort),
        .step(step), .dir(dir), .busy(busy), .done(done)
    );

    always #10 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [CH-1:0] st;
        logic [CH-1:0] di;
        logic [CH-1:0] bu;
        logic [CH-1:0] dn;
    } exp_t;

    exp_t          sb[$];
    logic [CH-1:0] e_st[NC];
    logic [CH-1:0] e_di[NC];
    logic [CH-1:0] e_bu[NC];
    logic [CH-1:0] e_dn[NC];
    logic [CH-1:0] cur_dir;
    int            win_lo, win_hi;
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_fail = 0;
    string         scen = "reset";

    task automatic cmp(string tag, logic [CH-1:0] obs, logic [CH-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s cycle %0d: observed %b expected %b", scen, tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        cyc++;
        #1;
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            cmp("step", step, e.st);
            cmp("dir",  dir,  e.di);
            cmp("busy", busy, e.bu);
            cmp("done", done, e.dn);
        end
    endtask

    task automatic run_until(int c);
        while (cyc < c) tick();
    endtask

    task automatic init_window(int lo, int hi);
        win_lo = lo;
        win_hi = hi;
        for (int c = lo; c <= hi; c++) begin
            e_st[c] = '0;
            e_bu[c] = '0;
            e_dn[c] = '0;
            e_di[c] = cur_dir;
        end
    endtask

    // Move loaded at edge t ending (or aborted) at edge end_c.
    task automatic span(int ch, int t, int end_c, logic d, bit ab);
        for (int c = t + 1; c <= win_hi; c++) e_di[c][ch] = d;
        for (int c = t + 1; c < end_c && c <= win_hi; c++) e_bu[c][ch] = 1'b1;
        if (!ab && end_c <= win_hi) e_dn[end_c][ch] = 1'b1;
        cur_dir[ch] = d;
    endtask

    task automatic rise(int ch, int r, int lim);
        for (int c = r; c < r + PW && c < lim && c <= win_hi; c++) e_st[c][ch] = 1'b1;
    endtask

    task automatic uniform(int ch, int t, int p, int n, logic d);
        span(ch, t, t + 2 + n * p, d, 1'b0);
        for (int k = 0; k < n; k++) rise(ch, t + 2 + k * p, NC);
    endtask

    task automatic commit();
        exp_t e;
        for (int c = win_lo; c <= win_hi; c++) begin
            e.cyc = c;
            e.st  = e_st[c];
            e.di  = e_di[c];
            e.bu  = e_bu[c];
            e.dn  = e_dn[c];
            sb.push_back(e);
        end
    endtask

    task automatic drained();
        n_cmp++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL %s/drain: observed %0d pending expected 0", scen, sb.size());
        end
        sb.delete();
    endtask

    task automatic set_ch(int ch, int per, int stp, logic d);
        period[ch*W +: W]   = W'(per);
        steps[ch*SW +: SW]  = SW'(stp);
        dir_in[ch]          = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        int t;
        rst = 1'b1; load = '0; period = '0; steps = '0; dir_in = '0;
        enable = '1; abort = 1'b0; cur_dir = '0;
        tick(); tick();
        cmp("rst_step", step, '0); cmp("rst_dir", dir, '0);
        cmp("rst_busy", busy, '0); cmp("rst_done", done, '0);
        rst = 1'b0;
        tick();

        scen = "basic";
        t = cyc + 1;
        init_window(t, t + 34);
        uniform(0, t, 10, 3, 1'b1);
        commit();
        set_ch(0, 10, 3, 1'b1); load = 2'b01;
        tick(); load = '0;
        run_until(t + 34); drained();

        scen = "clamp";
        t = cyc + 1;
        init_window(t, t + 14);
        uniform(1, t, 5, 2, 1'b1);
        commit();
        set_ch(1, 2, 2, 1'b1); load = 2'b10;
        tick(); load = '0;
        run_until(t + 14); drained();

        scen = "pause_retime";
        t = cyc + 1;
        init_window(t, t + 64);
        span(0, t, t + 61, 1'b1, 1'b0);
        rise(0, t + 2, NC); rise(0, t + 21, NC); rise(0, t + 31, NC); rise(0, t + 41, NC);
        commit();
        set_ch(0, 10, 4, 1'b1); load = 2'b01;
        tick(); load = '0;
        run_until(t + 8);  enable[0] = 1'b0;
        run_until(t + 20); enable[0] = 1'b1;
        run_until(t + 32); set_ch(0, 20, 4, 1'b1); load = 2'b01;
        tick(); load = '0;
        run_until(t + 64); drained();

        scen = "abort";
        t = cyc + 1;
        init_window(t, t + 15);
        span(0, t, t + 3, 1'b0, 1'b1);
        rise(0, t + 2, t + 3);
        commit();
        set_ch(0, 10, 3, 1'b0); load = 2'b01;
        tick(); load = '0;
        run_until(t + 2);
        set_ch(1, 10, 3, 1'b0); load = 2'b10; abort = 1'b1;
        tick(); load = '0; abort = 1'b0;
        run_until(t + 15); drained();

        scen = "zero_steps";
        t = cyc + 1;
        init_window(t, t + 4);
        e_dn[t + 1][1] = 1'b1;
        commit();
        set_ch(1, 10, 0, 1'b0); load = 2'b10;
        tick(); load = '0;
        run_until(t + 4); drained();

        scen = "busy_load";
        t = cyc + 1;
        init_window(t, t + 16);
        uniform(0, t, 6, 2, 1'b1);
        commit();
        set_ch(0, 6, 2, 1'b1); load = 2'b01;
        tick(); load = '0;
        run_until(t + 3);
        set_ch(0, 6, 7, 1'b0); load = 2'b01;
        tick(); load = '0;
        run_until(t + 16); drained();

        scen = "async_rst";
        t = cyc + 1;
        init_window(t, t + 3);
        uniform(0, t, 10, 3, 1'b1);
        commit();
        set_ch(0, 10, 3, 1'b1); load = 2'b01;
        tick(); load = '0;
        run_until(t + 3);
        #5 rst = 1'b1;
        #1;
        cmp("arst_step", step, '0); cmp("arst_dir", dir, '0);
        cmp("arst_busy", busy, '0); cmp("arst_done", done, '0);
        drained();
        tick(); rst = 1'b0; cur_dir = '0;
        tick();

        scen = "two_ch";
        t = cyc + 1;
        init_window(t, t + 34);
        uniform(0, t, 6, 5, 1'b1);
        uniform(1, t, 9, 2, 1'b0);
        commit();
        set_ch(0, 6, 5, 1'b1); set_ch(1, 9, 2, 1'b0); load = 2'b11;
        tick(); load = '0;
        run_until(t + 34); drained();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
